bp_mem_fixed_latency_responder: RTL



---
 rtl/bp_mem_fixed_latency_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bp_mem_fixed_latency_responder.sv
// Fixed-latency in-order memory responder with a small zero-initialised backing store.
// Commands update/read the store at acceptance; responses leave a circular queue once
// the head entry's latency timer has expired.
module bp_mem_fixed_latency_responder #(
    parameter int unsigned addr_width_p  = 40,
    parameter int unsigned block_width_p = 512,
    parameter int unsigned mem_els_p     = 64,
    parameter int unsigned els_p         = 4,
    parameter int unsigned latency_p     = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     mem_cmd_v_i,
    output logic                     mem_cmd_ready_o,
    input  logic                     mem_cmd_wr_i,
    input  logic [addr_width_p-1:0]  mem_cmd_addr_i,
    input  logic [block_width_p-1:0] mem_cmd_data_i,

    output logic                     mem_resp_v_o,
    input  logic                     mem_resp_yumi_i,
    output logic                     mem_resp_wr_o,
    output logic [addr_width_p-1:0]  mem_resp_addr_o,
    output logic [block_width_p-1:0] mem_resp_data_o
);

    localparam int unsigned off_lp   = $clog2(block_width_p / 8);
    localparam int unsigned idx_w_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int unsigned ptr_w_lp = $clog2(els_p);
    localparam int unsigned cnt_w_lp = ptr_w_lp + 1;
    localparam int unsigned tmr_w_lp = (latency_p == 0) ? 1 : $clog2(latency_p + 1);

    // Backing store
    logic [block_width_p-1:0] store_q [mem_els_p];
    logic [block_width_p-1:0] store_d [mem_els_p];

    // Queue entries
    logic                     wr_q    [els_p];
    logic                     wr_d    [els_p];
    logic [addr_width_p-1:0]  addr_q  [els_p];
    logic [addr_width_p-1:0]  addr_d  [els_p];
    logic [block_width_p-1:0] data_q  [els_p];
    logic [block_width_p-1:0] data_d  [els_p];
    logic [tmr_w_lp-1:0]      timer_q [els_p];
    logic [tmr_w_lp-1:0]      timer_d [els_p];
    logic [tmr_w_lp-1:0]      timer_dec [els_p];

    // Queue bookkeeping
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0] count_q,  count_d;

    logic                     enq;
    logic                     deq;
    logic [idx_w_lp-1:0]      idx;
    logic [block_width_p-1:0] rd_data;

    // Handshakes and head-of-queue outputs, all from registered state
    assign mem_cmd_ready_o = (count_q < cnt_w_lp'(els_p));
    assign mem_resp_v_o    = (count_q != '0) && (timer_q[rd_ptr_q] == '0);
    assign mem_resp_wr_o   = wr_q[rd_ptr_q];
    assign mem_resp_addr_o = addr_q[rd_ptr_q];
    assign mem_resp_data_o = data_q[rd_ptr_q];

    assign enq     = mem_cmd_v_i & mem_cmd_ready_o;
    assign deq     = mem_resp_yumi_i & mem_resp_v_o;
    assign idx     = mem_cmd_addr_i[off_lp +: idx_w_lp];
    assign rd_data = store_q[idx];

    // Per-entry saturating countdown of the latency timers
    for (genvar g = 0; g < int'(els_p); g++) begin : g_tmr
        assign timer_dec[g] = (timer_q[g] != '0) ? timer_q[g] - tmr_w_lp'(1) : timer_q[g];
    end

    // Store write on accepted write commands
    always_comb begin
        store_d = store_q;
        if (enq && mem_cmd_wr_i) begin
            store_d[idx] = mem_cmd_data_i;
        end
    end

    // Queue next state: enqueue at wr_ptr, dequeue at rd_ptr, count tracks occupancy
    always_comb begin
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        timer_d  = timer_dec;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (enq) begin
            wr_d[wr_ptr_q]    = mem_cmd_wr_i;
            addr_d[wr_ptr_q]  = mem_cmd_addr_i;
            // Reads capture the pre-write store value; writes respond with zero
            data_d[wr_ptr_q]  = mem_cmd_wr_i ? '0 : rd_data;
            timer_d[wr_ptr_q] = tmr_w_lp'(latency_p);
            wr_ptr_d          = wr_ptr_q + ptr_w_lp'(1);
        end

        if (deq) begin
            rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops all pending requests and clears the store
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            store_q  <= '{default: '0};
            wr_q     <= '{default: '0};
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            timer_q  <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            store_q  <= store_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            timer_q  <= timer_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Consumer must not take a response that is not offered
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        !(mem_resp_yumi_i && !mem_resp_v_o))
        else $error("mem_resp_yumi_i asserted while mem_resp_v_o low");

endmodule
